// File: rtl/alu_ctrl_seq.sv
// ALU control decoder with HI/LO ownership and an iterative
// shift-add multiplier / restoring divider sequencer.
module alu_ctrl_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       aluop,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [2:0]       aluctr,
  output logic [1:0]       out_sel,
  output logic             ctrl_valid,
  output logic             illegal,
  output logic             busy,
  output logic             md_done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {
    IDLE,
    MUL,
    DIV,
    FIX
  } state_e;

  state_e state_q, state_d;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             mul_q, mul_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic [2:0]       aluctr_q, aluctr_d;
  logic [1:0]       out_sel_q, out_sel_d;
  logic             ctrl_valid_q, ctrl_valid_d;
  logic             illegal_q, illegal_d;
  logic             md_done_q, md_done_d;
  logic             div0_q, div0_d;

  logic             accept;
  logic [2:0]       dec_ctr;
  logic [1:0]       dec_sel;
  logic             dec_ill;
  logic             dec_md;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem;
  logic [2*WIDTH-1:0] prod, prod_f;
  logic [WIDTH-1:0] fix_hi, fix_lo;

  assign in_ready = (state_q == IDLE);
  assign accept   = in_valid & in_ready;

  always_comb begin
    dec_ctr = aluop;
    dec_sel = 2'b00;
    dec_ill = 1'b0;
    dec_md  = 1'b0;
    if (aluop[2]) begin
      dec_ctr = 3'b000;
      unique case (1'b1)
        funct == 6'b100000:     dec_ctr = 3'b010;
        funct == 6'b100010:     dec_ctr = 3'b110;
        funct == 6'b100100:     dec_ctr = 3'b000;
        funct == 6'b100101:     dec_ctr = 3'b001;
        funct == 6'b101010:     dec_ctr = 3'b111;
        funct == 6'b010000:     dec_sel = 2'b01;
        funct == 6'b010010:     dec_sel = 2'b10;
        funct[5:2] == 4'b0110:  dec_md  = 1'b1;
        default:                dec_ill = 1'b1;
      endcase
    end
  end

  // funct[0] set means the unsigned variant
  assign a_neg = ~funct[0] & a[WIDTH-1];
  assign b_neg = ~funct[0] & b[WIDTH-1];
  assign a_mag = a_neg ? -a : a;
  assign b_mag = b_neg ? -b : b;

  assign mul_sum   = {1'b0, acc_q} + (sh_q[0] ? {1'b0, dvs_q} : '0);
  assign div_trial = {acc_q, sh_q[WIDTH-1]};
  assign div_ge    = div_trial >= {1'b0, dvs_q};
  assign div_rem   = div_ge ? div_trial[WIDTH-1:0] - dvs_q
                            : div_trial[WIDTH-1:0];

  assign prod   = {acc_q, sh_q};
  assign prod_f = negq_q ? -prod : prod;
  assign fix_hi = mul_q ? prod_f[2*WIDTH-1:WIDTH]
                        : (negr_q ? -acc_q : acc_q);
  assign fix_lo = mul_q ? prod_f[WIDTH-1:0]
                        : (negq_q ? -sh_q : sh_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    sh_d         = sh_q;
    dvs_d        = dvs_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    mul_d        = mul_q;
    negq_d       = negq_q;
    negr_d       = negr_q;
    aluctr_d     = aluctr_q;
    out_sel_d    = out_sel_q;
    ctrl_valid_d = accept;
    illegal_d    = 1'b0;
    md_done_d    = 1'b0;
    div0_d       = div0_q;

    if (accept) begin
      aluctr_d  = dec_ctr;
      out_sel_d = dec_sel;
      illegal_d = dec_ill;
    end

    case (state_q)
      IDLE: begin
        if (accept && dec_md) begin
          div0_d = 1'b0;
          mul_d  = ~funct[1];
          cnt_d  = CNT_W'(WIDTH - 1);
          acc_d  = '0;
          if (!funct[1]) begin
            state_d = MUL;
            sh_d    = b_mag;
            dvs_d   = a_mag;
            negq_d  = a_neg ^ b_neg;
            negr_d  = 1'b0;
          end else if (b == '0) begin
            // FIX copies acc/sh straight out with no sign fixup
            state_d = FIX;
            acc_d   = a;
            sh_d    = '1;
            negq_d  = 1'b0;
            negr_d  = 1'b0;
            div0_d  = 1'b1;
          end else begin
            state_d = DIV;
            sh_d    = a_mag;
            dvs_d   = b_mag;
            negq_d  = a_neg ^ b_neg;
            negr_d  = a_neg;
          end
        end
      end
      MUL: begin
        acc_d = mul_sum[WIDTH:1];
        sh_d  = {mul_sum[0], sh_q[WIDTH-1:1]};
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DIV: begin
        acc_d = div_rem;
        sh_d  = {sh_q[WIDTH-2:0], div_ge};
        if (cnt_q == '0) state_d = FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      FIX: begin
        hi_d      = fix_hi;
        lo_d      = fix_lo;
        md_done_d = 1'b1;
        cnt_d     = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      acc_q        <= '0;
      sh_q         <= '0;
      dvs_q        <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
      mul_q        <= 1'b0;
      negq_q       <= 1'b0;
      negr_q       <= 1'b0;
      aluctr_q     <= 3'b000;
      out_sel_q    <= 2'b00;
      ctrl_valid_q <= 1'b0;
      illegal_q    <= 1'b0;
      md_done_q    <= 1'b0;
      div0_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      sh_q         <= sh_d;
      dvs_q        <= dvs_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      mul_q        <= mul_d;
      negq_q       <= negq_d;
      negr_q       <= negr_d;
      aluctr_q     <= aluctr_d;
      out_sel_q    <= out_sel_d;
      ctrl_valid_q <= ctrl_valid_d;
      illegal_q    <= illegal_d;
      md_done_q    <= md_done_d;
      div0_q       <= div0_d;
    end
  end

  assign aluctr     = aluctr_q;
  assign out_sel    = out_sel_q;
  assign ctrl_valid = ctrl_valid_q;
  assign illegal    = illegal_q;
  assign busy       = (state_q != IDLE);
  assign md_done    = md_done_q;
  assign div0       = div0_q;
  assign hi         = hi_q;
  assign lo         = lo_q;

endmodule
